// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg : control-word layout shared by the decoder, ID/EX and EX/MEM stages
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package pipe_pkg;

  localparam int CTRL_W = 10;

  // Bit positions inside {RegWrite, MemtoReg, MemRead, MemWrite, Branch,
  // ALUSrc, RegDst, ALUOp[2:0]}
  localparam int CTRL_REGWRITE  = 9;
  localparam int CTRL_MEMTOREG  = 8;
  localparam int CTRL_MEMREAD   = 7;
  localparam int CTRL_MEMWRITE  = 6;
  localparam int CTRL_BRANCH    = 5;
  localparam int CTRL_ALUSRC    = 4;
  localparam int CTRL_REGDST    = 3;
  localparam int CTRL_ALUOP_MSB = 2;
  localparam int CTRL_ALUOP_LSB = 0;

  localparam int REG_W = 5;

  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

  // A producer can only be the source of a dependency when it writes a real
  // register; r0 is hard-wired to zero and never forwarded.
  function automatic logic reg_dep(input logic [REG_W-1:0] dst,
                                   input logic [REG_W-1:0] src);
    return (dst != '0) && (dst == src);
  endfunction

endpackage : pipe_pkg

`default_nettype wire

// File: rtl/load_use_detect.sv
// ----------------------------------------------------------------------------
// load_use_detect : flags an ID instruction that reads the destination of the
//                   load currently in EX
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module load_use_detect
  import pipe_pkg::*;
(
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  output logic             hazard_o
);

  logic rs_dep;
  logic rt_dep;

  always_comb begin
    rs_dep   = reg_dep(ex_rt_i, id_rs_i);
    rt_dep   = id_uses_rt_i && reg_dep(ex_rt_i, id_rt_i);
    hazard_o = ex_mem_read_i && (rs_dep || rt_dep);
  end

endmodule : load_use_detect

`default_nettype wire

// File: rtl/id_ex_hazard_stage.sv
// ----------------------------------------------------------------------------
// id_ex_hazard_stage : ID/EX pipeline register with load-use stall and
//                      branch-flush bubble insertion
// Revision           : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module id_ex_hazard_stage
  import pipe_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [REG_W-1:0]  if_id_Rs_i,
  input  logic [REG_W-1:0]  if_id_Rt_i,
  input  logic [REG_W-1:0]  if_id_Rd_i,
  input  logic              if_id_uses_rt_i,
  input  logic [DW-1:0]     rs_data_i,
  input  logic [DW-1:0]     rt_data_i,
  input  logic [DW-1:0]     imm_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [REG_W-1:0]  id_ex_RegRs_o,
  output logic [REG_W-1:0]  id_ex_RegRt_o,
  output logic [REG_W-1:0]  id_ex_RegRd_o,
  output logic [DW-1:0]     id_ex_rs_data_o,
  output logic [DW-1:0]     id_ex_rt_data_o,
  output logic [DW-1:0]     id_ex_imm_o,
  output logic [CTRL_W-1:0] id_ex_ctrl_o,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [REG_W-1:0]  rs_q,      rs_d;
  logic [REG_W-1:0]  rt_q,      rt_d;
  logic [REG_W-1:0]  rd_q,      rd_d;
  logic [DW-1:0]     rs_data_q, rs_data_d;
  logic [DW-1:0]     rt_data_q, rt_data_d;
  logic [DW-1:0]     imm_q,     imm_d;
  logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic hazard;
  logic stall;
  logic bubble;

  load_use_detect u_load_use_detect (
    .ex_mem_read_i (ctrl_q[CTRL_MEMREAD]),
    .ex_rt_i       (rt_q),
    .id_rs_i       (if_id_Rs_i),
    .id_rt_i       (if_id_Rt_i),
    .id_uses_rt_i  (if_id_uses_rt_i),
    .hazard_o      (hazard)
  );

  // A taken branch squashes the ID instruction anyway, so the PC must move to
  // the target rather than freeze for a stall.
  always_comb begin
    stall  = hazard && !flush_i;
    bubble = rst_i || flush_i || hazard;
  end

  always_comb begin
    rs_d      = if_id_Rs_i;
    rt_d      = if_id_Rt_i;
    rd_d      = if_id_Rd_i;
    rs_data_d = rs_data_i;
    rt_data_d = rt_data_i;
    imm_d     = imm_i;
    ctrl_d    = ctrl_i;
    if (bubble) begin
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      ctrl_d    = BUBBLE_CTRL;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (rst_i) begin
      stall_cnt_d = '0;
    end else if (stall && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rs_q        <= '0;
      rt_q        <= '0;
      rd_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      ctrl_q      <= BUBBLE_CTRL;
      stall_cnt_q <= '0;
    end else begin
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      rd_q        <= rd_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      ctrl_q      <= ctrl_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    id_ex_RegRs_o   = rs_q;
    id_ex_RegRt_o   = rt_q;
    id_ex_RegRd_o   = rd_q;
    id_ex_rs_data_o = rs_data_q;
    id_ex_rt_data_o = rt_data_q;
    id_ex_imm_o     = imm_q;
    id_ex_ctrl_o    = ctrl_q;
    pc_write_o      = !stall;
    if_id_write_o   = !stall;
    stall_cnt_o     = stall_cnt_q;
  end

endmodule : id_ex_hazard_stage

`default_nettype wire

// File: tb/tb_id_ex_hazard_stage.sv
// ----------------------------------------------------------------------------
// tb_id_ex_hazard_stage : directed bench with a rule-level reference model
// Revision              : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_id_ex_hazard_stage;

  localparam int DW = 32;

  localparam logic [9:0] C_LW   = 10'h390; // RegWrite MemtoReg MemRead ALUSrc
  localparam logic [9:0] C_ADD  = 10'h20A; // RegWrite RegDst ALUOp=010
  localparam logic [9:0] C_ADDI = 10'h210; // RegWrite ALUSrc

  logic          clk = 1'b0;
  logic          rst_i, flush_i, if_id_uses_rt_i;
  logic [4:0]    if_id_Rs_i, if_id_Rt_i, if_id_Rd_i;
  logic [DW-1:0] rs_data_i, rt_data_i, imm_i;
  logic [9:0]    ctrl_i;

  logic [4:0]    rs_o, rt_o, rd_o;
  logic [DW-1:0] rsd_o, rtd_o, imm_o;
  logic [9:0]    ctrl_o;
  logic          pcw_o, ifw_o;
  logic [15:0]   cnt_o;

  logic [4:0]    s_rs_o, s_rt_o, s_rd_o;
  logic [DW-1:0] s_rsd_o, s_rtd_o, s_imm_o;
  logic [9:0]    s_ctrl_o;
  logic          s_pcw_o, s_ifw_o;
  logic [1:0]    s_cnt_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_ex_hazard_stage #(.DW(DW), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .if_id_Rs_i(if_id_Rs_i), .if_id_Rt_i(if_id_Rt_i), .if_id_Rd_i(if_id_Rd_i),
    .if_id_uses_rt_i(if_id_uses_rt_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i), .ctrl_i(ctrl_i),
    .id_ex_RegRs_o(rs_o), .id_ex_RegRt_o(rt_o), .id_ex_RegRd_o(rd_o),
    .id_ex_rs_data_o(rsd_o), .id_ex_rt_data_o(rtd_o), .id_ex_imm_o(imm_o),
    .id_ex_ctrl_o(ctrl_o), .pc_write_o(pcw_o), .if_id_write_o(ifw_o),
    .stall_cnt_o(cnt_o)
  );

  // Narrow counter instance so saturation is reachable in a few stalls.
  id_ex_hazard_stage #(.DW(DW), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .if_id_Rs_i(if_id_Rs_i), .if_id_Rt_i(if_id_Rt_i), .if_id_Rd_i(if_id_Rd_i),
    .if_id_uses_rt_i(if_id_uses_rt_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i), .ctrl_i(ctrl_i),
    .id_ex_RegRs_o(s_rs_o), .id_ex_RegRt_o(s_rt_o), .id_ex_RegRd_o(s_rd_o),
    .id_ex_rs_data_o(s_rsd_o), .id_ex_rt_data_o(s_rtd_o), .id_ex_imm_o(s_imm_o),
    .id_ex_ctrl_o(s_ctrl_o), .pc_write_o(s_pcw_o), .if_id_write_o(s_ifw_o),
    .stall_cnt_o(s_cnt_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the ID/EX contents as a list of named fields plus the
  // number of stalls seen, updated from the stage rules at every rising edge.
  logic [4:0]    m_rs, m_rt, m_rd;
  logic [DW-1:0] m_rsd, m_rtd, m_imm;
  logic [9:0]    m_ctrl;
  int            m_cnt, m_cnt_s;
  bit            m_valid = 0;

  function automatic bit m_hazard();
    bit load_in_ex = m_ctrl[7];
    bit uses_load  = (m_rt == if_id_Rs_i) || (if_id_uses_rt_i && m_rt == if_id_Rt_i);
    return load_in_ex && (m_rt != 0) && uses_load;
  endfunction

  always @(posedge clk) begin
    bit h;
    h = m_hazard();
    if (rst_i) begin
      {m_rs, m_rt, m_rd, m_rsd, m_rtd, m_imm, m_ctrl} = '0;
      m_cnt = 0; m_cnt_s = 0; m_valid = 1;
    end else if (flush_i || h) begin
      {m_rs, m_rt, m_rd, m_rsd, m_rtd, m_imm, m_ctrl} = '0;
      if (h && !flush_i) begin
        m_cnt   = (m_cnt   < 65535) ? m_cnt + 1   : 65535;
        m_cnt_s = (m_cnt_s < 3)     ? m_cnt_s + 1 : 3;
      end
    end else begin
      m_rs = if_id_Rs_i; m_rt = if_id_Rt_i; m_rd = if_id_Rd_i;
      m_rsd = rs_data_i; m_rtd = rt_data_i; m_imm = imm_i; m_ctrl = ctrl_i;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      logic en;
      en = !(m_hazard() && !flush_i);
      chk("rs", rs_o, m_rs);
      chk("rt", rt_o, m_rt);
      chk("rd", rd_o, m_rd);
      chk("rs_data", rsd_o, m_rsd);
      chk("rt_data", rtd_o, m_rtd);
      chk("imm", imm_o, m_imm);
      chk("ctrl", ctrl_o, m_ctrl);
      chk("pc_write", pcw_o, en);
      chk("if_id_write", ifw_o, en);
      chk("stall_cnt", cnt_o, m_cnt);
      chk("sat_ctrl", s_ctrl_o, m_ctrl);
      chk("sat_pc_write", s_pcw_o, en);
      chk("sat_stall_cnt", s_cnt_o, m_cnt_s);
    end
  end

  task automatic id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                    input logic uses, input logic [DW-1:0] rsd, input logic [9:0] c);
    if_id_Rs_i = rs; if_id_Rt_i = rt; if_id_Rd_i = rd; if_id_uses_rt_i = uses;
    rs_data_i = rsd; rt_data_i = rsd ^ 32'hFFFF_0000; imm_i = {27'd0, rd}; ctrl_i = c;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0;
    id(5'd0, 5'd0, 5'd0, 1'b0, '0, '0);
    edge_step();
    edge_step();
    #1;
    chk("lit_reset_ctrl", ctrl_o, 10'h000);
    chk("lit_reset_cnt", cnt_o, 16'd0);
    chk("lit_reset_pcw", pcw_o, 1'b1);
    rst_i = 1'b0;

    // lw r8,0(r9) then add r10,r8,r11: one stall
    id(5'd9, 5'd8, 5'd0, 1'b0, 32'h0000_1000, C_LW);
    edge_step();
    id(5'd8, 5'd11, 5'd10, 1'b1, 32'hAAAA_0001, C_ADD);
    #1;
    chk("lit_lu_pcw", pcw_o, 1'b0);
    chk("lit_lu_ifw", ifw_o, 1'b0);
    edge_step(); #1;
    chk("lit_lu_bubble", ctrl_o, 10'h000);
    chk("lit_lu_cnt", cnt_o, 16'd1);
    chk("lit_lu_pcw_back", pcw_o, 1'b1);
    edge_step(); #1;
    chk("lit_lu_rs", rs_o, 5'd8);
    chk("lit_lu_ctrl", ctrl_o, C_ADD);

    // addi with Rt=8 does not read Rt
    id(5'd9, 5'd8, 5'd0, 1'b0, 32'h0000_2000, C_LW);
    edge_step();
    id(5'd1, 5'd8, 5'd0, 1'b0, 32'h0000_0005, C_ADDI);
    #1;
    chk("lit_addi_pcw", pcw_o, 1'b1);
    edge_step(); #1;
    chk("lit_addi_cnt", cnt_o, 16'd1);
    chk("lit_addi_ctrl", ctrl_o, C_ADDI);

    // load into r0 never stalls
    id(5'd5, 5'd0, 5'd0, 1'b0, 32'h0000_3000, C_LW);
    edge_step();
    id(5'd0, 5'd0, 5'd12, 1'b1, 32'h0, C_ADD);
    #1;
    chk("lit_r0_pcw", pcw_o, 1'b1);
    edge_step(); #1;
    chk("lit_r0_cnt", cnt_o, 16'd1);

    // hazard together with flush
    id(5'd9, 5'd8, 5'd0, 1'b0, 32'h0000_4000, C_LW);
    edge_step();
    id(5'd8, 5'd2, 5'd3, 1'b1, 32'h5555_5555, C_ADD);
    flush_i = 1'b1;
    #1;
    chk("lit_fl_pcw", pcw_o, 1'b1);
    chk("lit_fl_ifw", ifw_o, 1'b1);
    edge_step(); #1;
    flush_i = 1'b0;
    chk("lit_fl_ctrl", ctrl_o, 10'h000);
    chk("lit_fl_rs", rs_o, 5'd0);
    chk("lit_fl_cnt", cnt_o, 16'd1);

    // five more stalls: wide counter reaches 6, narrow one saturates at 3
    for (int i = 0; i < 5; i++) begin
      id(5'd9, 5'd7, 5'd0, 1'b0, 32'h100 + i, C_LW);
      edge_step();
      id(5'd4, 5'd7, 5'd6, 1'b1, 32'h200 + i, C_ADD);
      edge_step();
    end
    #1;
    chk("lit_sat_cnt", s_cnt_o, 2'd3);
    chk("lit_wide_cnt", cnt_o, 16'd6);

    // reset during a stall cycle
    id(5'd9, 5'd8, 5'd0, 1'b0, 32'h0000_6000, C_LW);
    edge_step();
    id(5'd8, 5'd11, 5'd10, 1'b1, 32'h7777_7777, C_ADD);
    rst_i = 1'b1;
    edge_step(); #1;
    chk("lit_rst_ctrl", ctrl_o, 10'h000);
    chk("lit_rst_rt", rt_o, 5'd0);
    chk("lit_rst_rsd", rsd_o, 32'h0);
    chk("lit_rst_cnt", cnt_o, 16'd0);
    rst_i = 1'b0;
    id(5'd3, 5'd4, 5'd5, 1'b1, 32'h1234_5678, C_ADD);
    edge_step(); #1;
    chk("lit_post_rs", rs_o, 5'd3);
    chk("lit_post_rt", rt_o, 5'd4);
    chk("lit_post_rsd", rsd_o, 32'h1234_5678);

    edge_step();
    edge_step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule : tb_id_ex_hazard_stage

`default_nettype wire
